uart_rx_fifo: RTL and testbench

Parametrised UART receiver with an integrated receive FIFO, replacing fixed-timing 8N1 decode loops with a synthesizable block. Oversamples a single asynchronous RX pad, validates start bit, samples data, optional parity and stop bits at mid-bit, and pushes good characters into a first-word-fall-through FIFO drained by a valid/ready consumer. Sits between the IO pad mux (e.g. the UART RX pad of a selected IP) and the SoC bus/peripheral logic.

---
 rtl/uart_rx_fifo.sv | 189 ++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - oversampling UART receiver feeding a first-word-fall-through receive FIFO
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 8,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          io_rx,
    output logic                          io_deq_valid,
    input  logic                          io_deq_ready,
    output logic [DATA_BITS-1:0]          io_deq_bits,
    output logic [$clog2(FIFO_DEPTH):0]   io_count,
    output logic                          io_busy,
    output logic                          io_frame_err,
    output logic                          io_parity_err,
    output logic                          io_overrun
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] HALF_RELOAD = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] BIT_RELOAD  = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;

    state_t                 state_q, state_n;
    logic [TW-1:0]          timer_q, timer_n;
    logic [IW-1:0]          idx_q, idx_n;
    logic [DATA_BITS-1:0]   data_q, data_n;
    logic                   par_err_q, par_err_n;
    logic                   stop_err_q, stop_err_n;
    logic                   stop_idx_q, stop_idx_n;
    logic                   char_done, char_fe, char_pe;

    logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]          count_q;
    logic                   pop, good, full_after_pop, push;
    logic                   frame_err_q, parity_err_q, overrun_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], io_rx};
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_n    = state_q;
        timer_n    = (timer_q != '0) ? timer_q - TW'(1) : timer_q;
        idx_n      = idx_q;
        data_n     = data_q;
        par_err_n  = par_err_q;
        stop_err_n = stop_err_q;
        stop_idx_n = stop_idx_q;
        char_done  = 1'b0;
        char_fe    = 1'b0;
        char_pe    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_n = START;
                    timer_n = HALF_RELOAD;
                end
            end
            START: begin
                if (timer_q == '0) begin
                    if (rx_s) begin
                        state_n = IDLE;
                    end else begin
                        state_n    = DATA;
                        timer_n    = BIT_RELOAD;
                        idx_n      = '0;
                        par_err_n  = 1'b0;
                        stop_err_n = 1'b0;
                        stop_idx_n = 1'b0;
                    end
                end
            end
            DATA: begin
                if (timer_q == '0) begin
                    data_n[idx_q] = rx_s;
                    timer_n       = BIT_RELOAD;
                    if (idx_q == IW'(DATA_BITS - 1)) begin
                        state_n = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        idx_n = idx_q + IW'(1);
                    end
                end
            end
            PARITY: begin
                if (timer_q == '0) begin
                    par_err_n = rx_s != ((^data_q) ^ (PARITY_ODD != 0));
                    timer_n   = BIT_RELOAD;
                    state_n   = STOP;
                end
            end
            STOP: begin
                if (timer_q == '0) begin
                    // Leave mid-stop-bit so a back-to-back start edge is never missed.
                    if (stop_idx_q == 1'(STOP_BITS - 1)) begin
                        state_n   = IDLE;
                        char_done = 1'b1;
                        char_fe   = stop_err_q | !rx_s;
                        char_pe   = par_err_q;
                    end else begin
                        stop_idx_n = 1'b1;
                        stop_err_n = stop_err_q | !rx_s;
                        timer_n    = BIT_RELOAD;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign pop            = io_deq_valid && io_deq_ready;
    assign good           = char_done && !char_fe && !char_pe;
    assign full_after_pop = (count_q == CW'(FIFO_DEPTH)) && !pop;
    assign push           = good && !full_after_pop;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            idx_q        <= '0;
            data_q       <= '0;
            par_err_q    <= 1'b0;
            stop_err_q   <= 1'b0;
            stop_idx_q   <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_n;
            timer_q      <= timer_n;
            idx_q        <= idx_n;
            data_q       <= data_n;
            par_err_q    <= par_err_n;
            stop_err_q   <= stop_err_n;
            stop_idx_q   <= stop_idx_n;
            frame_err_q  <= char_done && char_fe;
            parity_err_q <= char_done && !char_fe && char_pe;
            overrun_q    <= good && full_after_pop;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr_q] <= data_q;
        end
    end

    assign io_deq_valid  = count_q != '0;
    assign io_deq_bits   = io_deq_valid ? mem[rd_ptr_q] : '0;
    assign io_count      = count_q;
    assign io_busy       = state_q != IDLE;
    assign io_frame_err  = frame_err_q;
    assign io_parity_err = parity_err_q;
    assign io_overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - randomized and directed bench for uart_rx_fifo against a frame-level model
module tb_uart_rx_fifo;

    localparam int CPB = 16;

    typedef struct {
        int         tstart;
        int         tend;
        logic [7:0] data;
        bit         chr;
        bit         fe;
        bit         pe;
    } pend_t;

    logic       clock = 1'b0;
    logic       rst;
    logic       rx [2];
    logic       ready [2];
    logic       dv [2];
    logic [7:0] db [2];
    logic [3:0] cnt [2];
    logic       busy [2];
    logic       fe [2];
    logic       pe [2];
    logic       ov [2];

    pend_t      pq [2][$];
    logic [7:0] mq [2][$];
    logic [7:0] got [2][$];
    bit         e_fe [2];
    bit         e_pe [2];
    bit         e_ov [2];
    int         n_fe [2];
    int         n_pe [2];
    int         n_ov [2];
    int         cyc = 0;
    int         vectors = 0;
    int         miscompares = 0;
    bit         rand_ready = 1'b0;
    int         pop_at = -1;

    always #5 clock = ~clock;

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0),
                   .STOP_BITS(1), .FIFO_DEPTH(8), .SYNC_STAGES(2)) u0 (
        .clock(clock), .reset(rst), .io_rx(rx[0]), .io_deq_valid(dv[0]),
        .io_deq_ready(ready[0]), .io_deq_bits(db[0]), .io_count(cnt[0]), .io_busy(busy[0]),
        .io_frame_err(fe[0]), .io_parity_err(pe[0]), .io_overrun(ov[0]));

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0),
                   .STOP_BITS(2), .FIFO_DEPTH(8), .SYNC_STAGES(3)) u1 (
        .clock(clock), .reset(rst), .io_rx(rx[1]), .io_deq_valid(dv[1]),
        .io_deq_ready(ready[1]), .io_deq_bits(db[1]), .io_count(cnt[1]), .io_busy(busy[1]),
        .io_frame_err(fe[1]), .io_parity_err(pe[1]), .io_overrun(ov[1]));

    task automatic chk(input string name, input int u, input int got_v, input int exp_v);
        vectors++;
        if (got_v != exp_v) begin
            miscompares++;
            if (miscompares <= 40)
                $display("FAIL %s[u%0d] cycle %0d: got %0d, expected %0d", name, u, cyc, got_v, exp_v);
        end
    endtask

    // Frame-level model: each registered frame resolves at its last stop sample.
    task automatic checker_loop();
        pend_t p;
        forever begin
            @(posedge clock);
            cyc++;
            for (int u = 0; u < 2; u++) begin
                e_fe[u] = 0; e_pe[u] = 0; e_ov[u] = 0;
                if (!rst) begin
                    if (fe[u]) n_fe[u]++;
                    if (pe[u]) n_pe[u]++;
                    if (ov[u]) n_ov[u]++;
                    if (dv[u] && ready[u]) got[u].push_back(db[u]);
                    if (ready[u] && mq[u].size() > 0) void'(mq[u].pop_front());
                    while (pq[u].size() > 0 && pq[u][0].tend == cyc) begin
                        p = pq[u].pop_front();
                        if (p.chr) begin
                            if (p.fe) e_fe[u] = 1;
                            else if (p.pe) e_pe[u] = 1;
                            else if (mq[u].size() == 8) e_ov[u] = 1;
                            else mq[u].push_back(p.data);
                        end
                    end
                end
            end
            @(negedge clock);
            for (int u = 0; u < 2; u++) begin
                if (rst) begin
                    pq[u].delete(); mq[u].delete();
                    e_fe[u] = 0; e_pe[u] = 0; e_ov[u] = 0;
                end
                chk("deq_valid", u, dv[u], mq[u].size() > 0);
                chk("deq_bits", u, db[u], mq[u].size() > 0 ? mq[u][0] : 0);
                chk("count", u, cnt[u], mq[u].size());
                chk("busy", u, busy[u], pq[u].size() > 0 && cyc >= pq[u][0].tstart);
                chk("frame_err", u, fe[u], e_fe[u]);
                chk("parity_err", u, pe[u], e_pe[u]);
                chk("overrun", u, ov[u], e_ov[u]);
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
            if (pop_at == cyc + 1) ready[0] = 1'b1;
            else if (pop_at == cyc) ready[0] = 1'b0;
            else if (rand_ready) begin
                ready[0] = 1'($urandom_range(0, 1));
                ready[1] = 1'($urandom_range(0, 1));
            end
        end
    endtask

    // u0: 8N1, u1: 8E2. Sample points follow from the start edge reaching rx_s.
    task automatic send_frame(input int u, input logic [7:0] d, input bit par, input bit s0,
                              input bit s1, input bit coincide, input int gap);
        pend_t p;
        int    nsync = (u == 0) ? 2 : 3;
        int    nbits = (u == 0) ? 9 : 11;
        bit    last  = (u == 0) ? s0 : s1;
        p.tstart = cyc + nsync + 1;
        p.tend   = p.tstart + CPB / 2 + nbits * CPB;
        p.data   = d;
        p.chr    = 1;
        p.fe     = (u == 0) ? !s0 : (!s0 || !s1);
        p.pe     = (u == 0) ? 1'b0 : (par != (^d));
        pq[u].push_back(p);
        if (!last) begin
            p.tstart = p.tend + 1;
            p.tend   = p.tstart + CPB / 2;
            p.chr    = 0;
            pq[u].push_back(p);
        end
        if (coincide) pop_at = pq[u][pq[u].size() - 1].tend;
        rx[u] = 1'b0; tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx[u] = d[i]; tick(CPB);
        end
        if (u == 1) begin
            rx[u] = par; tick(CPB);
        end
        rx[u] = s0; tick(CPB);
        if (u == 1) begin
            rx[u] = s1; tick(CPB);
        end
        rx[u] = 1'b1;
        tick(gap + (last ? 0 : CPB));
    endtask

    task automatic drain(input int u);
        ready[u] = 1'b1; tick(12); ready[u] = 1'b0; tick(1);
    endtask

    initial begin
        int b_fe, b_pe, b_ov, g0;
        pend_t p;
        rst = 1'b1;
        rx[0] = 1'b1; rx[1] = 1'b1;
        ready[0] = 1'b0; ready[1] = 1'b0;
        fork
            checker_loop();
        join_none
        tick(4);
        chk("reset_count", 0, cnt[0], 0);
        chk("reset_valid", 1, dv[1], 0);
        rst = 1'b0;
        tick(3);

        b_fe = n_fe[0]; b_pe = n_pe[0]; b_ov = n_ov[0];
        for (int i = 1; i <= 4; i++) send_frame(0, 8'(i), 1'b0, 1'b1, 1'b1, 1'b0, 0);
        tick(2);
        chk("four_count", 0, cnt[0], 4);
        chk("four_no_err", 0, n_fe[0] + n_pe[0] + n_ov[0] - b_fe - b_pe - b_ov, 0);
        g0 = got[0].size();
        drain(0);
        chk("four_drain_n", 0, got[0].size() - g0, 4);
        for (int i = 0; i < 4; i++)
            if (g0 + i < got[0].size()) chk("four_drain", 0, got[0][g0 + i], i + 1);
        chk("four_empty", 0, dv[0], 0);

        b_fe = n_fe[0];
        p.tstart = cyc + 3; p.tend = p.tstart + CPB / 2; p.data = 0; p.chr = 0; p.fe = 0; p.pe = 0;
        pq[0].push_back(p);
        rx[0] = 1'b0; tick(CPB / 4); rx[0] = 1'b1; tick(2 * CPB);
        chk("glitch_count", 0, cnt[0], 0);
        chk("glitch_busy", 0, busy[0], 0);
        chk("glitch_fe", 0, n_fe[0] - b_fe, 0);

        b_fe = n_fe[0];
        send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, CPB);
        chk("frame_fe", 0, n_fe[0] - b_fe, 1);
        chk("frame_count", 0, cnt[0], 0);
        send_frame(0, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, 2);
        g0 = got[0].size();
        drain(0);
        chk("frame_next_n", 0, got[0].size() - g0, 1);
        if (g0 < got[0].size()) chk("frame_next", 0, got[0][g0], 8'h3C);

        b_pe = n_pe[1];
        send_frame(1, 8'h03, 1'b1, 1'b1, 1'b1, 1'b0, 2);
        chk("par_pe", 1, n_pe[1] - b_pe, 1);
        chk("par_drop", 1, cnt[1], 0);
        send_frame(1, 8'h03, 1'b0, 1'b1, 1'b1, 1'b0, 2);
        chk("par_ok_count", 1, cnt[1], 1);
        g0 = got[1].size();
        drain(1);
        if (g0 < got[1].size()) chk("par_ok_data", 1, got[1][g0], 8'h03);
        else chk("par_ok_n", 1, got[1].size() - g0, 1);

        for (int rep = 0; rep < 2; rep++) begin
            b_ov = n_ov[0];
            for (int i = 0; i < 9; i++)
                send_frame(0, 8'(8'h10 + i), 1'b0, 1'b1, 1'b1, (rep == 1) && (i == 8), 2);
            tick(2);
            pop_at = -1;
            chk("ovr_count", 0, cnt[0], 8);
            chk("ovr_pulses", 0, n_ov[0] - b_ov, (rep == 0) ? 1 : 0);
            g0 = (rep == 0) ? got[0].size() : got[0].size() - 1;
            drain(0);
            chk("ovr_drain_n", 0, got[0].size() - g0, (rep == 0) ? 8 : 9);
            for (int i = 0; i < 9; i++)
                if (g0 + i < got[0].size()) chk("ovr_drain", 0, got[0][g0 + i], 8'h10 + i);
        end

        send_frame(0, 8'h11, 1'b0, 1'b1, 1'b1, 1'b0, 2);
        p.tstart = cyc + 3; p.tend = cyc + 100000; p.data = 8'h5A; p.chr = 1; p.fe = 0; p.pe = 0;
        pq[0].push_back(p);
        rx[0] = 1'b0; tick(CPB);
        for (int i = 0; i < 4; i++) begin
            rx[0] = (i == 1 || i == 3); tick((i == 3) ? CPB / 2 : CPB);
        end
        rst = 1'b1; rx[0] = 1'b1; tick(3);
        chk("rst_count", 0, cnt[0], 0);
        chk("rst_busy", 0, busy[0], 0);
        rst = 1'b0; tick(2);
        chk("rst_valid", 0, dv[0], 0);
        send_frame(0, 8'h5A, 1'b0, 1'b1, 1'b1, 1'b0, 2);
        chk("rst_next_count", 0, cnt[0], 1);
        g0 = got[0].size();
        drain(0);
        if (g0 < got[0].size()) chk("rst_next", 0, got[0][g0], 8'h5A);
        else chk("rst_next_n", 0, got[0].size() - g0, 1);

        rand_ready = 1'b1;
        for (int k = 0; k < 25; k++) begin
            logic [7:0] d;
            bit s0;
            d  = 8'($urandom);
            s0 = $urandom_range(0, 7) != 0;
            send_frame(0, d, 1'b0, s0, 1'b1, 1'b0, $urandom_range(0, CPB));
        end
        for (int k = 0; k < 25; k++) begin
            logic [7:0] d;
            bit par, s0, s1;
            d   = 8'($urandom);
            par = (^d) ^ ($urandom_range(0, 5) == 0);
            s0  = $urandom_range(0, 7) != 0;
            s1  = $urandom_range(0, 7) != 0;
            send_frame(1, d, par, s0, s1, 1'b0, $urandom_range(0, CPB));
        end
        rand_ready = 1'b0;
        ready[0] = 1'b1; ready[1] = 1'b1;
        tick(20);
        chk("final_empty", 0, cnt[0], 0);
        chk("final_empty", 1, cnt[1], 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
